// File: rtl/parc_core_rob.sv
// In-order reorder buffer: allocate at tail, out-of-order fill, in-order commit from head.
// Commit is available one cycle after the head is filled; alloc stalls when full or flushing.
module parc_core_rob #(
   parameter int ENTRIES    = 16,
   parameter int DATA_W     = 32,
   parameter int AREG_W     = 5,
   parameter int FILL_PORTS = 2,
   parameter int READ_PORTS = 2,
   localparam int SW        = $clog2(ENTRIES)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         alloc_val,
   input  logic                         alloc_wen,
   input  logic [AREG_W-1:0]            alloc_waddr,
   output logic                         alloc_rdy,
   output logic [SW-1:0]                alloc_slot,
   input  logic [FILL_PORTS-1:0]        fill_val,
   input  logic [FILL_PORTS*SW-1:0]     fill_slot,
   input  logic [FILL_PORTS*DATA_W-1:0] fill_data,
   input  logic [READ_PORTS*SW-1:0]     rd_slot,
   output logic [READ_PORTS*DATA_W-1:0] rd_data,
   output logic [READ_PORTS-1:0]        rd_pend,
   output logic                         commit_val,
   input  logic                         commit_rdy,
   output logic                         commit_wen,
   output logic [AREG_W-1:0]            commit_waddr,
   output logic [DATA_W-1:0]            commit_data,
   output logic [SW-1:0]                commit_slot,
   input  logic                         flush,
   output logic [SW:0]                  count,
   output logic                         empty,
   output logic                         full
);

   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] filled;
   logic               wen_q   [ENTRIES];
   logic [AREG_W-1:0]  waddr_q [ENTRIES];
   logic [DATA_W-1:0]  data_q  [ENTRIES];
   logic [SW-1:0]      head;
   logic [SW-1:0]      tail;
   logic [SW:0]        cnt;

   logic [ENTRIES-1:0] fill_hit;
   logic [ENTRIES-1:0] fill_wr;
   logic [DATA_W-1:0]  fill_word [ENTRIES];
   logic               alloc_fire;
   logic               commit_fire;

   assign count        = cnt;
   assign empty        = (cnt == '0);
   assign full         = (cnt == (SW+1)'(ENTRIES));
   assign alloc_rdy    = !full && !flush;
   assign alloc_slot   = tail;
   assign alloc_fire   = alloc_val && alloc_rdy;
   assign commit_val   = valid[head] && filled[head] && !flush;
   assign commit_fire  = commit_val && commit_rdy;
   assign commit_wen   = wen_q[head];
   assign commit_waddr = waddr_q[head];
   assign commit_data  = data_q[head];
   assign commit_slot  = head;

   // Per-slot fill decode; ascending port scan lets the highest port win.
   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         fill_hit[e]  = 1'b0;
         fill_word[e] = '0;
         for (int p = 0; p < FILL_PORTS; p++) begin
            if (fill_val[p] && fill_slot[p*SW +: SW] == SW'(e)) begin
               fill_hit[e]  = 1'b1;
               fill_word[e] = fill_data[p*DATA_W +: DATA_W];
            end
         end
         // Validity is the registered bit, so a fill racing an alloc of the same slot is dropped.
         fill_wr[e] = fill_hit[e] && valid[e] && !flush;
      end
   end

   always_comb begin
      logic [SW-1:0] s;
      rd_data = '0;
      rd_pend = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         s = rd_slot[r*SW +: SW];
         rd_data[r*DATA_W +: DATA_W] = fill_hit[s] ? fill_word[s] : data_q[s];
         rd_pend[r] = valid[s] && !filled[s] && !fill_hit[s];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid  <= '0;
         filled <= '0;
         head   <= '0;
         tail   <= '0;
         cnt    <= '0;
      end else begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (fill_wr[e]) filled[e] <= 1'b1;
         end
         if (commit_fire) begin
            valid[head] <= 1'b0;
            head        <= head + SW'(1);
         end
         if (alloc_fire) begin
            valid[tail]  <= 1'b1;
            filled[tail] <= 1'b0;
            tail         <= tail + SW'(1);
         end
         cnt <= cnt + (SW+1)'(alloc_fire) - (SW+1)'(commit_fire);
      end
   end

   // Payload arrays carry no reset; valid/filled qualify every use.
   always_ff @(posedge clk) begin
      for (int e = 0; e < ENTRIES; e++) begin
         if (fill_wr[e]) data_q[e] <= fill_word[e];
      end
      if (alloc_fire) begin
         wen_q[tail]   <= alloc_wen;
         waddr_q[tail] <= alloc_waddr;
      end
   end

endmodule
